// File: rtl/decoder_3to8_seq.sv
// decoder_3to8_seq
// ----------------
// Sequential 3-to-8 one-hot decoder. 3-bit codes arrive through a valid/ready
// handshake into a small FIFO. Each code is later driven on 'out' as a
// registered one-hot word (8'b1 << code) that stays asserted for exactly HOLD
// cycles. Codes come out in the order they were accepted.
//
// Handshake: a code transfers on a rising edge where in_valid && in_ready.
// in_ready is !full and is combinational from the FIFO count. in_valid while
// full is ignored and nothing is overwritten.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_code    code to decode
//   in_valid   in_code is valid this cycle
//   in_ready   FIFO can accept a code
//   en         permits starting a new output word (never cuts one short)
//   out        registered one-hot word, 8'b0 when idle
//   out_valid  out holds a decoded word
//   busy       a word is being held or the FIFO is non-empty
//   fifo_level current FIFO occupancy
module decoder_3to8_seq #(
  parameter int DEPTH = 4,
  parameter int HOLD  = 2,
  parameter int LW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    in_code,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          en,
  output logic [7:0]    out,
  output logic          out_valid,
  output logic          busy,
  output logic [LW-1:0] fifo_level
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD_ST = 1'b1
  } state_t;

  state_t          state;
  logic [HW-1:0]   hold_cnt;

  logic [2:0]      mem [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [LW-1:0]   count;

  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic [2:0]      pop_code;

  assign full     = (count == LW'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full;
  assign push     = in_valid && !full;

  // A new word starts either from IDLE or on the last cycle of the current
  // word, which gives back-to-back words with no zero gap between them.
  assign pop      = !empty && en && ((state == IDLE) || (hold_cnt == '0));
  assign pop_code = mem[rptr];

  assign busy       = (state == HOLD_ST) || !empty;
  assign fifo_level = count;

  // Storage carries no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= in_code;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + AW'(1);
      end
      if (pop) begin
        rptr <= rptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  // Output FSM. hold_cnt counts the remaining cycles of the current word
  // after this one, so a word is loaded with HOLD-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      out       <= 8'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            state     <= HOLD_ST;
            hold_cnt  <= HW'(HOLD - 1);
            out       <= 8'(1) << pop_code;
            out_valid <= 1'b1;
          end else begin
            out       <= 8'b0;
            out_valid <= 1'b0;
          end
        end
        HOLD_ST: begin
          if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - HW'(1);
          end else if (pop) begin
            hold_cnt  <= HW'(HOLD - 1);
            out       <= 8'(1) << pop_code;
            out_valid <= 1'b1;
          end else begin
            state     <= IDLE;
            out       <= 8'b0;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          hold_cnt  <= '0;
          out       <= 8'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
